// File: rtl/cbi980_pkg.sv
// Shared definitions for the cbi980 port: FSM encoding, slot limits and the
// register map used by the core and the serializer.
package cbi980_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOT1 = 2'd1,
    ST_SLOT0 = 2'd2
  } state_e;

  localparam int MAX_OCTETS = 4;

  localparam logic [7:0] REG_CR    = 8'h00;
  localparam logic [7:0] REG_LCFR  = 8'h04;
  localparam logic [7:0] REG_SR    = 8'h08;
  localparam logic [7:0] REG_DOUT1 = 8'h0C;
  localparam logic [7:0] REG_DOUT0 = 8'h10;

  // Out-of-range octet counts (0 or above MAX_OCTETS) mean a full-width slot.
  function automatic logic [2:0] eff_octets(input logic [2:0] oct);
    if (oct == 3'd0 || oct > 3'(MAX_OCTETS)) return 3'(MAX_OCTETS);
    return oct;
  endfunction

endpackage

// File: rtl/cbi980_tx_serializer_clkdiv.sv
// Bit-clock divider: bclk toggles every rate+1 clk cycles while run is high,
// and is parked low with a cleared count while run is low.
module cbi980_tx_serializer_clkdiv #(
  parameter int RATE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [RATE_W-1:0] rate,
  output logic              bclk,
  output logic              rise_tick,
  output logic              fall_tick
);

  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic              bclk_q, bclk_d;
  logic              tick;

  assign tick = run && (cnt_q == rate);

  always_comb begin
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (!run) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk      = bclk_q;
  assign rise_tick = tick && !bclk_q;
  assign fall_tick = tick && bclk_q;

endmodule

// File: rtl/cbi980_tx_serializer.sv
// cbi980 transmit back end: frames ch1/ch0 words into a two-slot serial stream.
//   state    | meaning
//   ST_IDLE  | stopped; bclk/fsync/sdout held low
//   ST_SLOT1 | shifting the ch1 word, fsync high
//   ST_SLOT0 | shifting the ch0 word, fsync low
module cbi980_tx_serializer
  import cbi980_pkg::*;
#(
  parameter int DW     = 32,
  parameter int RATE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [RATE_W-1:0] mclk_rate,
  input  logic [2:0]        octet_cnt,
  input  logic              rjust,
  input  logic              lsb_first,
  input  logic [DW-1:0]     ch1_data,
  input  logic              ch1_valid,
  output logic              ch1_ready,
  input  logic [DW-1:0]     ch0_data,
  input  logic              ch0_valid,
  output logic              ch0_ready,
  output logic              bclk,
  output logic              fsync,
  output logic              sdout,
  output logic [1:0]        underrun,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DW-1:0]     shreg_q, shreg_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic              fsync_q, fsync_d;
  logic [1:0]        underrun_q, underrun_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [2:0]        octets_q, octets_d;
  logic              rjust_q, rjust_d;
  logic              lsb_q, lsb_d;

  logic       fall_tick, rise_tick_unused;
  logic [5:0] nbits;
  logic       last_bit, slot_end, start1, start0;

  // Places the selected slot field so that its first-sent bit sits at DW-1.
  function automatic logic [DW-1:0] slot_field(input logic [DW-1:0] word,
                                               input logic [2:0] octs,
                                               input logic rj, input logic lsb);
    logic [5:0]    gap;
    logic [DW-1:0] f, r;
    gap = 6'(DW) - {octs, 3'b000};
    f   = rj ? (word & ({DW{1'b1}} >> gap)) : (word >> gap);
    r   = '0;
    if (lsb) begin
      for (int i = 0; i < DW; i++) r[DW-1-i] = f[i];
    end else begin
      r = f << gap;
    end
    return r;
  endfunction

  cbi980_tx_serializer_clkdiv #(.RATE_W(RATE_W)) u_clkdiv (
    .clk       (clk),
    .rst       (rst),
    .run       (busy),
    .rate      (rate_q),
    .bclk      (bclk),
    .rise_tick (rise_tick_unused),
    .fall_tick (fall_tick)
  );

  assign busy     = (state_q != ST_IDLE);
  assign nbits    = {octets_q, 3'b000};
  assign last_bit = ({1'b0, bit_cnt_q} == nbits - 6'd1);
  assign slot_end = fall_tick && last_bit;
  // Leaving IDLE counts as the falling tick that opens slot 1.
  assign start1   = en && ((state_q == ST_IDLE) || (state_q == ST_SLOT0 && slot_end));
  assign start0   = (state_q == ST_SLOT1) && slot_end;

  assign ch1_ready = rst && start1;
  assign ch0_ready = rst && start0;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    fsync_d    = fsync_q;
    underrun_d = 2'b00;
    rate_d     = rate_q;
    octets_d   = octets_q;
    rjust_d    = rjust_q;
    lsb_d      = lsb_q;
    if (start1) begin
      state_d       = ST_SLOT1;
      rate_d        = mclk_rate;
      octets_d      = eff_octets(octet_cnt);
      rjust_d       = rjust;
      lsb_d         = lsb_first;
      shreg_d       = slot_field(ch1_valid ? ch1_data : '0, eff_octets(octet_cnt),
                                 rjust, lsb_first);
      bit_cnt_d     = '0;
      fsync_d       = 1'b1;
      underrun_d[1] = !ch1_valid;
    end else if (start0) begin
      state_d       = ST_SLOT0;
      shreg_d       = slot_field(ch0_valid ? ch0_data : '0, octets_q, rjust_q, lsb_q);
      bit_cnt_d     = '0;
      fsync_d       = 1'b0;
      underrun_d[0] = !ch0_valid;
    end else if (state_q == ST_SLOT0 && slot_end) begin
      state_d   = ST_IDLE;
      shreg_d   = '0;
      bit_cnt_d = '0;
      fsync_d   = 1'b0;
    end else if (fall_tick) begin
      shreg_d   = shreg_q << 1;
      bit_cnt_d = bit_cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      fsync_q    <= 1'b0;
      underrun_q <= 2'b00;
      rate_q     <= '0;
      octets_q   <= 3'(MAX_OCTETS);
      rjust_q    <= 1'b0;
      lsb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      fsync_q    <= fsync_d;
      underrun_q <= underrun_d;
      rate_q     <= rate_d;
      octets_q   <= octets_d;
      rjust_q    <= rjust_d;
      lsb_q      <= lsb_d;
    end
  end

  assign fsync    = fsync_q;
  assign sdout    = shreg_q[DW-1];
  assign underrun = underrun_q;

endmodule

// File: tb/tb_cbi980_tx_serializer.sv
// Bench for cbi980_tx_serializer: directed vector table, hand sequences for
// abort/reset/rate-hold, and a randomized run against a bit-stream model.
module tb_cbi980_tx_serializer;

  logic        clk, rst, en;
  logic [2:0]  mclk_rate, octet_cnt;
  logic        rjust, lsb_first;
  logic [31:0] ch1_data, ch0_data;
  logic        ch1_valid, ch0_valid, ch1_ready, ch0_ready;
  logic        bclk, fsync, sdout, busy;
  logic [1:0]  underrun;

  cbi980_tx_serializer dut (
    .clk(clk), .rst(rst), .en(en), .mclk_rate(mclk_rate), .octet_cnt(octet_cnt),
    .rjust(rjust), .lsb_first(lsb_first),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
    .ch0_data(ch0_data), .ch0_valid(ch0_valid), .ch0_ready(ch0_ready),
    .bclk(bclk), .fsync(fsync), .sdout(sdout), .underrun(underrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor and reference model ----------------
  logic [1:0] rxq[$];
  logic [1:0] expq[$];
  int cyc = 0, r1_cnt = 0, r0_cnt = 0, u1_cnt = 0, u0_cnt = 0, exp_u1 = 0, exp_u0 = 0;
  int per_bad = 0, first_bad = 0, last_rise = 0, start_cyc = 0;
  int exp_period = 0;
  bit have_rise = 0, first_pend = 0;
  logic prev_bclk = 1'b0;
  logic [2:0] m_oct;
  logic m_rj, m_lsb;

  function automatic void push_slot(input logic [31:0] w, input logic [2:0] oct,
                                    input logic rj, input logic lsb, input logic fs);
    int n;
    longint unsigned field;
    n = (oct == 0 || oct > 4) ? 32 : 8 * int'(oct);
    if (rj) field = longint'(w) % (64'd1 << n);
    else    field = longint'(w) / (64'd1 << (32 - n));
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = lsb ? k : n - 1 - k;
      expq.push_back({fs, ((field >> idx) & 64'd1) != 0});
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!busy) have_rise = 0;
    if (ch1_ready) begin
      r1_cnt++;
      if (!ch1_valid) exp_u1++;
      if (!busy) begin start_cyc = cyc; first_pend = 1; end
      m_oct = octet_cnt; m_rj = rjust; m_lsb = lsb_first;
      push_slot(ch1_valid ? ch1_data : 32'h0, m_oct, m_rj, m_lsb, 1'b1);
    end
    if (ch0_ready) begin
      r0_cnt++;
      if (!ch0_valid) exp_u0++;
      push_slot(ch0_valid ? ch0_data : 32'h0, m_oct, m_rj, m_lsb, 1'b0);
    end
    if (underrun[1]) u1_cnt++;
    if (underrun[0]) u0_cnt++;
    if (bclk && !prev_bclk) begin
      rxq.push_back({fsync, sdout});
      if (exp_period != 0) begin
        if (have_rise && (cyc - last_rise) != exp_period) per_bad++;
        if (first_pend && (cyc - start_cyc) != exp_period / 2 + 1) first_bad++;
      end
      first_pend = 0;
      have_rise  = 1;
      last_rise  = cyc;
    end
    prev_bclk = bclk;
  end

  // ---------------- helpers ----------------
  task automatic wait_ready1(input string nm, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (ch1_ready) break;
    end
    check(nm, 64'(ch1_ready), 64'd1);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(nm, 64'(busy), 64'd0);
  endtask

  task automatic wait_rise(output int n);
    logic pb;
    pb = bclk;
    n  = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (bclk && !pb) begin n = c; break; end
      pb = bclk;
    end
  endtask

  task automatic rand_ch1();
    ch1_data  = $urandom;
    ch1_valid = ($urandom_range(0, 7) != 0);
    mclk_rate = 3'($urandom_range(0, 2));
    octet_cnt = 3'($urandom_range(0, 7));
    rjust     = 1'($urandom_range(0, 1));
    lsb_first = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_ch0();
    ch0_data  = $urandom;
    ch0_valid = ($urandom_range(0, 7) != 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  rate, oct;
    logic        rj, lsb;
    logic [31:0] d1, d0;
    logic        v1, v0;
    int          en_drop;
    int          n;
    logic [31:0] e1, e0;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int br, r1b, r0b, u1b, u0b, pb, fb, be, eu1b, eu0b, fs_err, mism, d, p;
    logic [31:0] got1, got0;
    logic [1:0]  e;
    logic        rd1, rd0;

    vecs[0] = '{3'd0, 3'd2, 1'b0, 1'b0, 32'hA5C3_0000, 32'h1234_0000, 1'b1, 1'b1, 0,  16, 32'hA5C3,     32'h1234};
    vecs[1] = '{3'd0, 3'd1, 1'b1, 1'b1, 32'h0000_00B1, 32'h0000_0012, 1'b1, 1'b1, 5,  8,  32'h8D,       32'h48};
    vecs[2] = '{3'd1, 3'd2, 1'b0, 1'b0, 32'hA5C3_0000, 32'h1234_0000, 1'b1, 1'b0, 3,  16, 32'hA5C3,     32'h0};
    vecs[3] = '{3'd1, 3'd4, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b1, 13, 32, 32'hDEADBEEF, 32'h01234567};
    vecs[4] = '{3'd2, 3'd0, 1'b1, 1'b1, 32'h8000_0001, 32'h0000_000F, 1'b1, 1'b1, 20, 32, 32'h80000001, 32'hF0000000};
    vecs[5] = '{3'd0, 3'd7, 1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_0000, 1'b1, 1'b1, 7,  32, 32'h1E6A2C48, 32'h0000FFFF};
    vecs[6] = '{3'd1, 3'd3, 1'b0, 1'b0, 32'hABCD_EF12, 32'h1122_3344, 1'b1, 1'b1, 2,  24, 32'hABCDEF,   32'h112233};
    vecs[7] = '{3'd0, 3'd3, 1'b1, 1'b0, 32'hABCD_EF12, 32'h1122_3344, 1'b0, 1'b1, 1,  24, 32'h0,        32'h223344};

    rst = 1'b0; en = 1'b0; mclk_rate = 3'd0; octet_cnt = 3'd0; rjust = 1'b0; lsb_first = 1'b0;
    ch1_data = '0; ch0_data = '0; ch1_valid = 1'b1; ch0_valid = 1'b1;

    // reset state, with en high to show no ready in reset cycles
    repeat (2) @(posedge clk);
    #1 en = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'({ch1_ready, ch0_ready}), 64'd0);
    check("rst_outputs", 64'({bclk, fsync, sdout, underrun, busy}), 64'd0);
    @(posedge clk);
    #1 en = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;

    // table-driven single frames (en drops during slot 1)
    for (int i = 0; i < 8; i++) begin
      mclk_rate = vecs[i].rate; octet_cnt = vecs[i].oct;
      rjust = vecs[i].rj; lsb_first = vecs[i].lsb;
      ch1_data = vecs[i].d1; ch0_data = vecs[i].d0;
      ch1_valid = vecs[i].v1; ch0_valid = vecs[i].v0;
      exp_period = 2 * (int'(vecs[i].rate) + 1);
      br = rxq.size(); r1b = r1_cnt; r0b = r0_cnt; u1b = u1_cnt; u0b = u0_cnt;
      pb = per_bad; fb = first_bad;
      en = 1'b1;
      wait_ready1($sformatf("v%0d_start", i), 20);
      @(posedge clk);
      repeat (vecs[i].en_drop) @(posedge clk);
      #1 en = 1'b0;
      wait_idle($sformatf("v%0d_idle", i));
      got1 = '0; got0 = '0; fs_err = 0;
      check($sformatf("v%0d_nbits", i), 64'(rxq.size() - br), 64'(2 * vecs[i].n));
      for (int k = 0; k < rxq.size() - br; k++) begin
        e = rxq[br + k];
        if (k < vecs[i].n) begin got1 = {got1[30:0], e[0]}; if (!e[1]) fs_err++; end
        else begin got0 = {got0[30:0], e[0]}; if (e[1]) fs_err++; end
      end
      check($sformatf("v%0d_slot1", i), 64'(got1), 64'(vecs[i].e1));
      check($sformatf("v%0d_slot0", i), 64'(got0), 64'(vecs[i].e0));
      check($sformatf("v%0d_fsync", i), 64'(fs_err), 64'd0);
      check($sformatf("v%0d_ready", i), 64'({r1_cnt - r1b, r0_cnt - r0b}), {32'd1, 32'd1});
      check($sformatf("v%0d_underrun", i), 64'({u1_cnt - u1b, u0_cnt - u0b}),
            {32'(!vecs[i].v1), 32'(!vecs[i].v0)});
      check($sformatf("v%0d_bclk_period", i), 64'(per_bad - pb), 64'd0);
      check($sformatf("v%0d_first_rise", i), 64'(first_bad - fb), 64'd0);
      check($sformatf("v%0d_idle_out", i), 64'({bclk, fsync, sdout, underrun}), 64'd0);
      @(posedge clk);
      #1;
    end

    // reset during slot 0, bit 5; restart must fetch ch1 first
    exp_period = 0;
    mclk_rate = 3'd0; octet_cnt = 3'd4; rjust = 1'b0; lsb_first = 1'b0;
    ch1_data = 32'hFFFF_FFFF; ch0_data = 32'hFFFF_FFFF; ch1_valid = 1'b1; ch0_valid = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ch0_ready) break;
    end
    check("rst_mid_reach_slot0", 64'(ch0_ready), 64'd1);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    check("rst_cycle_ready", 64'({ch1_ready, ch0_ready}), 64'd0);
    @(negedge clk);
    check("rst_mid_outputs", 64'({bclk, fsync, sdout, underrun, busy, ch1_ready, ch0_ready}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ch1_ready || ch0_ready) break;
    end
    check("restart_first_fetch", 64'({ch1_ready, ch0_ready}), 64'b10);
    @(posedge clk);
    #1 en = 1'b0;
    wait_idle("restart_idle");

    // rate changed mid-frame is held until the next frame
    mclk_rate = 3'd1; octet_cnt = 3'd0;
    @(posedge clk);
    #1 en = 1'b1;
    wait_ready1("t6_start", 20);
    @(posedge clk);
    #1 mclk_rate = 3'd3;
    wait_rise(d);
    wait_rise(p);
    check("t6_rate_held", 64'(p), 64'd4);
    wait_ready1("t6_next_frame", 400);
    @(posedge clk);
    #1 en = 1'b0;
    wait_rise(d);
    wait_rise(p);
    check("t6_rate_new", 64'(p), 64'd8);
    wait_idle("t6_idle");

    // randomized back-to-back frames with en glitches, checked against the model
    exp_period = 0;
    rand_ch1(); rand_ch0();
    be = expq.size(); br = rxq.size(); r1b = r1_cnt;
    eu1b = exp_u1; eu0b = exp_u0; u1b = u1_cnt; u0b = u0_cnt;
    @(posedge clk);
    #1 en = 1'b1;
    for (int c = 0; c < 30000; c++) begin
      if (r1_cnt - r1b >= 12) break;
      @(negedge clk);
      rd1 = ch1_ready; rd0 = ch0_ready;
      @(posedge clk);
      #1;
      if (rd1) rand_ch1();
      if (rd0) rand_ch0();
      en = ($urandom_range(0, 15) != 0);
    end
    check("rand_frames", 64'(r1_cnt - r1b >= 12), 64'd1);
    en = 1'b0;
    wait_idle("rand_idle");
    check("rand_len", 64'(rxq.size() - br), 64'(expq.size() - be));
    mism = 0;
    for (int k = 0; k < rxq.size() - br && k < expq.size() - be; k++)
      if (rxq[br + k] !== expq[be + k]) mism++;
    check("rand_stream", 64'(mism), 64'd0);
    check("rand_underrun1", 64'(u1_cnt - u1b), 64'(exp_u1 - eu1b));
    check("rand_underrun0", 64'(u0_cnt - u0b), 64'(exp_u0 - eu0b));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
